frame_sequencer: RTL and testbench
==================================

# frame_sequencer

Controller that sequences the detection datapath for one frame at a time. It accepts a raster pixel stream over a valid/ready handshake and drives the datapath's enable, pixel data and x/y location. After the last pixel it flushes the row-buffer pipeline, then sweeps object IDs 1..num_labels and returns each object's centroid over a second valid/ready handshake. It sits between the frame source (camera/DMA) and the datapath top level, and owns `en`, `x`, `y`, `data` and `obj_id`.

## Interface
Parameters:
- FRAME_W, `FRAME_WIDTH`: pixels per row.
- FRAME_H, `FRAME_HEIGHT`: rows per frame.
- FLUSH_CYCLES, 2*`FRAME_WIDTH`+8: enabled cycles after the last pixel, so the Sobel, flood and CC windows fully drain.
- LOOKUP_LAT, 2: cycles from an `obj_id` change until `obj_x`/`obj_y` are valid.

Ports:
- clk, in, 1: clock; all logic is on posedge.
- reset, in, 1: reset, asynchronous, active-high.
- start, in, 1: begin a frame; sampled only in IDLE or DONE.
- in_valid, in, 1: a pixel is offered.
- in_ready, out, 1: the sequencer accepts the pixel.
- in_data, in, `PIXEL_SIZE`: RGB pixel.
- pipe_en, out, 1: datapath enable.
- pipe_x, out, `LOC_SIZE`: column of the current pixel.
- pipe_y, out, `LOC_SIZE`: row of the current pixel.
- pipe_data, out, `PIXEL_SIZE`: pixel sent to the datapath.
- num_labels, in, `WORD_SIZE`: label count from the datapath.
- obj_id, out, `WORD_SIZE`: object selected for lookup.
- obj_x, in, `LOC_SIZE`: centroid x from the datapath.
- obj_y, in, `LOC_SIZE`: centroid y from the datapath.
- rpt_valid, out, 1: a report is presented.
- rpt_ready, in, 1: the consumer accepts the report.
- rpt_id, out, `WORD_SIZE`: object ID of the report.
- rpt_x, out, `LOC_SIZE`: centroid x of the report.
- rpt_y, out, `LOC_SIZE`: centroid y of the report.
- busy, out, 1: high in every state except IDLE and DONE.
- done, out, 1: one-cycle pulse when the frame completes.

## Operation
State machine and transitions:
- **IDLE**
  - start → STREAM; clear x/y.
- **STREAM**
  - in_ready=1.
  - Accept when in_valid&in_ready: pipe_en=1, pipe_data=in_data.
  - x increments on every accept. At FRAME_W-1, x wraps to 0 and y increments.
  - Accepting x=FRAME_W-1, y=FRAME_H-1 → FLUSH. That pixel is still presented with its own coordinates.
  - No accept that cycle: pipe_en=0, and pipe_data holds its value.
- **FLUSH**
  - in_ready=0, pipe_en=1, pipe_data=0.
  - x/y hold at the final pixel.
  - Down-counter loads FLUSH_CYCLES-1 on entry; the state exits when the counter reaches 0.
  - Exit → RPT_SET when num_labels≠0, else → DONE.
- **RPT_SET**
  - obj_id increments; it is 1 on the first entry.
  - Wait counter loads LOOKUP_LAT.
  - → RPT_WAIT.
- **RPT_WAIT**
  - Counts down.
  - At 0: capture obj_x/obj_y/obj_id into rpt_x/rpt_y/rpt_id → RPT_OUT.
- **RPT_OUT**
  - rpt_valid=1; the rpt_* fields are stable until accepted.
  - On rpt_valid&rpt_ready: → RPT_SET if obj_id<num_labels, else → DONE.
- **DONE**
  - done pulses on the entry cycle.
  - start → STREAM; otherwise stay.

Arithmetic and sampling rules:
- num_labels is sampled once at FLUSH exit into a register. Later changes are ignored.
- The x/y/obj_id counters are unsigned and never exceed their bounds.

Boundary conditions:
- start during any busy state: ignored.
- in_valid during FLUSH or a report state: not accepted (in_ready=0).
- num_labels=0: no reports; done is asserted 1 cycle after FLUSH ends.
- num_labels=255: 255 reports; obj_id never wraps to 0.
- rpt_ready held low: stall in RPT_OUT indefinitely; pipe_en stays 0.
- reset at any time: immediately to IDLE, mid-frame state is discarded, no done pulse.

## Timing
- Reset values:
  - all outputs 0;
  - state IDLE;
  - pipe_x=pipe_y=0;
  - obj_id=0.
- pipe_en and pipe_data are combinational from the handshake. pipe_x/pipe_y are registers holding the coordinate of the pixel presented this cycle.
- start → in_ready: 1 cycle.
- Last accept → first FLUSH cycle: 1 cycle. FLUSH lasts exactly FLUSH_CYCLES cycles with pipe_en high.
- Each report takes 2+LOOKUP_LAT cycles of overhead plus the rpt_ready wait.
- With rpt_ready tied high and N labels, FLUSH exit to done takes N·(LOOKUP_LAT+2)+1 cycles.

## Configuration
- `FRAME_SEQ_REPORT_EN` defined: the report sweep above is compiled in.
- `FRAME_SEQ_REPORT_EN` undefined:
  - the RPT_* states are removed, and FLUSH → DONE always;
  - rpt_valid is tied 0, obj_id is tied 0, rpt_* are tied 0;
  - the obj_x/obj_y/num_labels inputs are unused.

## Structure
- Shared header `global.vh` supplies `FRAME_WIDTH`, `FRAME_HEIGHT`, `LOC_SIZE`, `WORD_SIZE` and `PIXEL_SIZE`.
- State encodings are added there as `SEQ_IDLE`..`SEQ_DONE` localparam-style defines.
- One sub-module, raster_counter: x/y counter with enable, clear and last-pixel flag.

## Test plan
Benches use FRAME_W=8, FRAME_H=4, FLUSH_CYCLES=24, LOOKUP_LAT=2.
1. Reset, start, 32 back-to-back pixels → pipe_x/pipe_y sequence (0,0)..(7,3); then 24 cycles of pipe_en=1 with pipe_data=0.
2. in_valid toggled every other cycle → pipe_en follows the accepts only; the coordinates advance only on accept; 32 accepts total.
3. num_labels=3, rpt_ready=1, obj_x/obj_y = id·10 → reports (1,10,10), (2,20,20), (3,30,30); done fires 1 cycle after the third report.
4. num_labels=0 → no rpt_valid; done fires 1 cycle after FLUSH; busy falls in the same cycle.
5. rpt_ready held 0 for 50 cycles in RPT_OUT → rpt_valid=1 with stable fields; start is ignored.
6. reset asserted mid-STREAM at pixel 13 → all outputs 0 asynchronously. A new start then begins at (0,0).

Source files
------------

// File: rtl/frame_sequencer_pkg.sv
// Shared frame geometry, bus widths and sequencer state encodings for frame_sequencer.
package frame_sequencer_pkg;

    localparam int FRAME_WIDTH  = 8;
    localparam int FRAME_HEIGHT = 4;
    localparam int LOC_SIZE     = 8;
    localparam int WORD_SIZE    = 8;
    localparam int PIXEL_SIZE   = 24;

    typedef enum logic [2:0] {
        SEQ_IDLE     = 3'd0,
        SEQ_STREAM   = 3'd1,
        SEQ_FLUSH    = 3'd2,
        SEQ_RPT_SET  = 3'd3,
        SEQ_RPT_WAIT = 3'd4,
        SEQ_RPT_OUT  = 3'd5,
        SEQ_DONE     = 3'd6
    } seq_state_t;

endpackage

// File: rtl/frame_sequencer_raster_counter.sv
// Raster x/y counter: advances on enable, wraps x at row end, and parks on the last pixel of the frame.
module raster_counter
    import frame_sequencer_pkg::*;
#(
    parameter int W = FRAME_WIDTH,
    parameter int H = FRAME_HEIGHT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                en,
    output logic [LOC_SIZE-1:0] x,
    output logic [LOC_SIZE-1:0] y,
    output logic                last
);

    assign last = (x == LOC_SIZE'(W - 1)) && (y == LOC_SIZE'(H - 1));

    // Holding at the last pixel keeps the final coordinate visible through the flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (en && !last) begin
            if (x == LOC_SIZE'(W - 1)) begin
                x <= '0;
                y <= y + LOC_SIZE'(1);
            end else begin
                x <= x + LOC_SIZE'(1);
            end
        end
    end

endmodule

// File: rtl/frame_sequencer.sv
// Frame sequencer: streams one frame into the detection datapath, flushes it, then sweeps
// object centroids. The report sweep is compiled in only when FRAME_SEQ_REPORT_EN is defined.
module frame_sequencer
    import frame_sequencer_pkg::*;
#(
    parameter int FRAME_W      = FRAME_WIDTH,
    parameter int FRAME_H      = FRAME_HEIGHT,
    parameter int FLUSH_CYCLES = 2 * FRAME_WIDTH + 8,
    parameter int LOOKUP_LAT   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PIXEL_SIZE-1:0] in_data,
    output logic                  pipe_en,
    output logic [LOC_SIZE-1:0]   pipe_x,
    output logic [LOC_SIZE-1:0]   pipe_y,
    output logic [PIXEL_SIZE-1:0] pipe_data,
    input  logic [WORD_SIZE-1:0]  num_labels,
    output logic [WORD_SIZE-1:0]  obj_id,
    input  logic [LOC_SIZE-1:0]   obj_x,
    input  logic [LOC_SIZE-1:0]   obj_y,
    output logic                  rpt_valid,
    input  logic                  rpt_ready,
    output logic [WORD_SIZE-1:0]  rpt_id,
    output logic [LOC_SIZE-1:0]   rpt_x,
    output logic [LOC_SIZE-1:0]   rpt_y,
    output logic                  busy,
    output logic                  done
);

    localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);

    seq_state_t            state;
    logic [FLUSH_W-1:0]    flush_cnt;
    logic [PIXEL_SIZE-1:0] data_hold;
    logic                  accept;
    logic                  last_pixel;
    logic                  clear_xy;

    assign in_ready  = (state == SEQ_STREAM);
    assign accept    = in_ready && in_valid;
    assign pipe_en   = accept || (state == SEQ_FLUSH);
    assign pipe_data = (state == SEQ_FLUSH) ? '0 : (accept ? in_data : data_hold);
    assign busy      = (state != SEQ_IDLE) && (state != SEQ_DONE);
    assign clear_xy  = start && !busy;

    raster_counter #(
        .W(FRAME_W),
        .H(FRAME_H)
    ) u_raster (
        .clk  (clk),
        .reset(reset),
        .clear(clear_xy),
        .en   (accept),
        .x    (pipe_x),
        .y    (pipe_y),
        .last (last_pixel)
    );

    // Idle cycles replay the last accepted pixel; the flush zeroes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_hold <= '0;
        end else if (accept) begin
            data_hold <= in_data;
        end else if (state == SEQ_FLUSH) begin
            data_hold <= '0;
        end
    end

`ifdef FRAME_SEQ_REPORT_EN
    localparam int LAT_W = $clog2(LOOKUP_LAT + 1);

    logic [WORD_SIZE-1:0] labels;
    logic [LAT_W-1:0]     lat_cnt;

    assign rpt_valid = (state == SEQ_RPT_OUT);
`else
    logic unused_rpt_inputs;

    assign unused_rpt_inputs = ^{num_labels, obj_x, obj_y, rpt_ready};
    assign rpt_valid = 1'b0;
    assign obj_id    = '0;
    assign rpt_id    = '0;
    assign rpt_x     = '0;
    assign rpt_y     = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SEQ_IDLE;
            flush_cnt <= '0;
            done      <= 1'b0;
`ifdef FRAME_SEQ_REPORT_EN
            obj_id    <= '0;
            labels    <= '0;
            lat_cnt   <= '0;
            rpt_id    <= '0;
            rpt_x     <= '0;
            rpt_y     <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                SEQ_IDLE, SEQ_DONE: begin
                    if (start) begin
                        state <= SEQ_STREAM;
`ifdef FRAME_SEQ_REPORT_EN
                        obj_id <= '0;
`endif
                    end
                end
                SEQ_STREAM: begin
                    if (accept && last_pixel) begin
                        state     <= SEQ_FLUSH;
                        flush_cnt <= FLUSH_W'(FLUSH_CYCLES - 1);
                    end
                end
                SEQ_FLUSH: begin
                    if (flush_cnt == '0) begin
`ifdef FRAME_SEQ_REPORT_EN
                        labels <= num_labels;
                        if (num_labels != '0) begin
                            state  <= SEQ_RPT_SET;
                            obj_id <= obj_id + WORD_SIZE'(1);
                        end else begin
                            state <= SEQ_DONE;
                            done  <= 1'b1;
                        end
`else
                        state <= SEQ_DONE;
                        done  <= 1'b1;
`endif
                    end else begin
                        flush_cnt <= flush_cnt - FLUSH_W'(1);
                    end
                end
`ifdef FRAME_SEQ_REPORT_EN
                SEQ_RPT_SET: begin
                    lat_cnt <= LAT_W'(LOOKUP_LAT);
                    state   <= SEQ_RPT_WAIT;
                end
                // Capturing as the count expires keeps each report at LOOKUP_LAT+2 cycles.
                SEQ_RPT_WAIT: begin
                    if (lat_cnt <= LAT_W'(1)) begin
                        rpt_id <= obj_id;
                        rpt_x  <= obj_x;
                        rpt_y  <= obj_y;
                        state  <= SEQ_RPT_OUT;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                SEQ_RPT_OUT: begin
                    if (rpt_ready) begin
                        if (obj_id < labels) begin
                            state  <= SEQ_RPT_SET;
                            obj_id <= obj_id + WORD_SIZE'(1);
                        end else begin
                            state <= SEQ_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
`endif
                default: state <= SEQ_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer on an 8x4 frame with a 24-cycle flush and 2-cycle lookup.
module tb_frame_sequencer;
    import frame_sequencer_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  start = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [PIXEL_SIZE-1:0] in_data = '0;
    logic                  pipe_en;
    logic [LOC_SIZE-1:0]   pipe_x;
    logic [LOC_SIZE-1:0]   pipe_y;
    logic [PIXEL_SIZE-1:0] pipe_data;
    logic [WORD_SIZE-1:0]  num_labels = '0;
    logic [WORD_SIZE-1:0]  obj_id;
    logic [LOC_SIZE-1:0]   obj_x = '0;
    logic [LOC_SIZE-1:0]   obj_y = '0;
    logic [LOC_SIZE-1:0]   obj_d = '0;
    logic                  rpt_valid;
    logic                  rpt_ready = 1'b0;
    logic [WORD_SIZE-1:0]  rpt_id;
    logic [LOC_SIZE-1:0]   rpt_x;
    logic [LOC_SIZE-1:0]   rpt_y;
    logic                  busy;
    logic                  done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Two-register centroid lookup: object n sits at (10n, 10n).
    always @(posedge clk) begin
        obj_d <= LOC_SIZE'(obj_id * 8'd10);
        obj_x <= obj_d;
        obj_y <= obj_d;
    end

    frame_sequencer #(
        .FRAME_W(8), .FRAME_H(4), .FLUSH_CYCLES(24), .LOOKUP_LAT(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .pipe_en(pipe_en), .pipe_x(pipe_x), .pipe_y(pipe_y),
        .pipe_data(pipe_data), .num_labels(num_labels), .obj_id(obj_id), .obj_x(obj_x),
        .obj_y(obj_y), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_id(rpt_id),
        .rpt_x(rpt_x), .rpt_y(rpt_y), .busy(busy), .done(done)
    );

    task automatic start_frame();
        @(negedge clk);
        start = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL start_ready_early got %b want 0", in_ready);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = PIXEL_SIZE'(24'h800000 + i);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({in_ready, pipe_en, pipe_x, pipe_y, pipe_data, obj_id, rpt_valid, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b en=%b x=%0d y=%0d d=%h id=%0d rv=%b busy=%b done=%b want all 0",
                     in_ready, pipe_en, pipe_x, pipe_y, pipe_data, obj_id, rpt_valid, busy, done);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        int bad_pix = 0;
        int bad_flush = 0;
        num_labels = '0;
        start_frame();
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1;
            in_data  = PIXEL_SIZE'(24'h100000 + i * 3);
            #1;
            checks++;
            if ({in_ready, pipe_en, pipe_x, pipe_y, pipe_data, busy} !==
                {1'b1, 1'b1, LOC_SIZE'(i % 8), LOC_SIZE'(i / 8), in_data, 1'b1}) begin
                errors++;
                bad_pix++;
                $display("FAIL stream_pixel_%0d got rdy=%b en=%b x=%0d y=%0d d=%h want 1 1 %0d %0d %h",
                         i, in_ready, pipe_en, pipe_x, pipe_y, pipe_data, i % 8, i / 8, in_data);
            end
            @(negedge clk);
        end
        // Offer pixels through the flush: none may be accepted.
        for (int f = 0; f < 24; f++) begin
            in_valid = 1'b1;
            in_data  = 24'hABCDEF;
            #1;
            checks++;
            if ({in_ready, pipe_en, pipe_x, pipe_y, pipe_data, busy, done} !==
                {1'b0, 1'b1, LOC_SIZE'(7), LOC_SIZE'(3), PIXEL_SIZE'(0), 1'b1, 1'b0}) begin
                errors++;
                bad_flush++;
                $display("FAIL flush_cycle_%0d got rdy=%b en=%b x=%0d y=%0d d=%h busy=%b done=%b want 0 1 7 3 0 1 0",
                         f, in_ready, pipe_en, pipe_x, pipe_y, pipe_data, busy, done);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        checks++;
        if ({done, busy, pipe_en, rpt_valid} !== 4'b1000) begin
            errors++;
            $display("FAIL flush_to_done got done=%b busy=%b en=%b rv=%b want 1 0 0 0", done, busy, pipe_en, rpt_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse_width got %b want 0", done);
        end
    endtask

    task automatic test_throttled();
        int acc = 0;
        int c = 0;
        int done_cyc = -1;
        logic [PIXEL_SIZE-1:0] hold = '0;
        start_frame();
        while (acc < 32 && c < 100) begin
            in_valid = (c % 2 == 0);
            in_data  = PIXEL_SIZE'(24'h200000 + c);
            #1;
            checks++;
            if ({pipe_en, pipe_x, pipe_y, pipe_data} !==
                {in_valid, LOC_SIZE'(acc % 8), LOC_SIZE'(acc / 8), (in_valid ? in_data : hold)}) begin
                errors++;
                $display("FAIL throttle_cycle_%0d got en=%b x=%0d y=%0d d=%h want %b %0d %0d %h",
                         c, pipe_en, pipe_x, pipe_y, pipe_data, in_valid, acc % 8, acc / 8,
                         (in_valid ? in_data : hold));
            end
            if (in_valid) begin
                hold = in_data;
                acc++;
            end
            c++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (acc !== 32 || c !== 63) begin
            errors++;
            $display("FAIL throttle_accepts got acc=%0d cycles=%0d want 32 63", acc, c);
        end
        for (int k = 0; k < 40 && done_cyc < 0; k++) begin
            #1;
            if (done === 1'b1) done_cyc = k;
            @(negedge clk);
        end
        checks++;
        if (done_cyc !== 24) begin
            errors++;
            $display("FAIL throttle_done_cycle got %0d want 24", done_cyc);
        end
    endtask

`ifdef FRAME_SEQ_REPORT_EN
    task automatic test_reports();
        int n_rpt = 0;
        int done_cyc = -1;
        int exp_cyc[3] = '{27, 31, 35};
        num_labels = 8'd3;
        rpt_ready  = 1'b1;
        start_frame();
        run_pixels(32);
        for (int k = 0; k < 60; k++) begin
            #1;
            if (rpt_valid === 1'b1) begin
                checks++;
                if (n_rpt >= 3 || {rpt_id, rpt_x, rpt_y} !==
                    {WORD_SIZE'(n_rpt + 1), LOC_SIZE'((n_rpt + 1) * 10), LOC_SIZE'((n_rpt + 1) * 10)} ||
                    k != exp_cyc[n_rpt % 3]) begin
                    errors++;
                    $display("FAIL report_%0d got id=%0d x=%0d y=%0d cyc=%0d want id=%0d x=%0d y=%0d cyc=%0d",
                             n_rpt, rpt_id, rpt_x, rpt_y, k, n_rpt + 1, (n_rpt + 1) * 10,
                             (n_rpt + 1) * 10, exp_cyc[n_rpt % 3]);
                end
                n_rpt++;
            end
            if (done === 1'b1 && done_cyc < 0) done_cyc = k;
            @(negedge clk);
        end
        checks++;
        if (n_rpt !== 3 || done_cyc !== 36) begin
            errors++;
            $display("FAIL report_sweep got reports=%0d done_cyc=%0d want 3 36", n_rpt, done_cyc);
        end
    endtask

    task automatic test_stall();
        int found = 0;
        int done_seen = 0;
        num_labels = 8'd2;
        rpt_ready  = 1'b0;
        start_frame();
        run_pixels(32);
        for (int k = 0; k < 60 && found == 0; k++) begin
            #1;
            if (rpt_valid === 1'b1) found = 1;
            else @(negedge clk);
        end
        checks++;
        if (found == 0) begin
            errors++;
            $display("FAIL stall_first_report got none want rpt_valid");
        end
        @(negedge clk);
        num_labels = 8'd1;
        for (int k = 0; k < 50; k++) begin
            start = (k == 10);
            #1;
            checks++;
            if ({rpt_valid, rpt_id, rpt_x, rpt_y, pipe_en, in_ready, busy} !==
                {1'b1, WORD_SIZE'(1), LOC_SIZE'(10), LOC_SIZE'(10), 1'b0, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL stall_cycle_%0d got rv=%b id=%0d x=%0d y=%0d en=%b rdy=%b busy=%b want 1 1 10 10 0 0 1",
                         k, rpt_valid, rpt_id, rpt_x, rpt_y, pipe_en, in_ready, busy);
            end
            @(negedge clk);
        end
        start = 1'b0;
        rpt_ready = 1'b1;
        @(negedge clk);
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            #1;
            if (rpt_valid === 1'b1) found = 1;
            else @(negedge clk);
        end
        checks++;
        if (found == 0 || {rpt_id, rpt_x, rpt_y} !== {WORD_SIZE'(2), LOC_SIZE'(20), LOC_SIZE'(20)}) begin
            errors++;
            $display("FAIL stall_second_report got found=%0d id=%0d x=%0d y=%0d want 1 2 20 20",
                     found, rpt_id, rpt_x, rpt_y);
        end
        for (int k = 0; k < 10 && done_seen == 0; k++) begin
            @(negedge clk);
            #1;
            if (done === 1'b1) done_seen = 1;
        end
        checks++;
        if (done_seen == 0) begin
            errors++;
            $display("FAIL stall_done got no done want pulse");
        end
    endtask
`else
    task automatic test_no_reports();
        int rv_seen = 0;
        int id_bad = 0;
        int done_cyc = -1;
        num_labels = 8'd3;
        rpt_ready  = 1'b1;
        start_frame();
        run_pixels(32);
        for (int k = 0; k < 40; k++) begin
            #1;
            if (rpt_valid !== 1'b0) rv_seen++;
            if ({obj_id, rpt_id, rpt_x, rpt_y} !== '0) id_bad++;
            if (done === 1'b1 && done_cyc < 0) done_cyc = k;
            @(negedge clk);
        end
        checks++;
        if (rv_seen != 0 || id_bad != 0 || done_cyc != 24) begin
            errors++;
            $display("FAIL no_report_build got rv=%0d idbad=%0d done_cyc=%0d want 0 0 24", rv_seen, id_bad, done_cyc);
        end
    endtask
`endif

    task automatic test_reset_mid_frame();
        int done_seen = 0;
        start_frame();
        run_pixels(13);
        in_valid = 1'b1;
        in_data  = 24'h00FF00;
        #1;
        checks++;
        if ({pipe_x, pipe_y, pipe_en} !== {LOC_SIZE'(5), LOC_SIZE'(1), 1'b1}) begin
            errors++;
            $display("FAIL mid_pixel_13 got x=%0d y=%0d en=%b want 5 1 1", pipe_x, pipe_y, pipe_en);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({in_ready, pipe_en, pipe_x, pipe_y, pipe_data, obj_id, rpt_valid, busy, done} !== '0) begin
            errors++;
            $display("FAIL async_reset got rdy=%b en=%b x=%0d y=%0d d=%h busy=%b done=%b want all 0",
                     in_ready, pipe_en, pipe_x, pipe_y, pipe_data, busy, done);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            if (done === 1'b1) done_seen = 1;
        end
        reset = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            if (done === 1'b1) done_seen = 1;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL reset_done_pulse got done pulse want none");
        end
        start_frame();
        in_valid = 1'b1;
        in_data  = 24'h123456;
        #1;
        checks++;
        if ({in_ready, pipe_en, pipe_x, pipe_y, pipe_data} !== {1'b1, 1'b1, LOC_SIZE'(0), LOC_SIZE'(0), 24'h123456}) begin
            errors++;
            $display("FAIL restart_origin got rdy=%b en=%b x=%0d y=%0d d=%h want 1 1 0 0 123456",
                     in_ready, pipe_en, pipe_x, pipe_y, pipe_data);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_throttled();
`ifdef FRAME_SEQ_REPORT_EN
        test_reports();
        test_stall();
`else
        test_no_reports();
`endif
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
